// File: rtl/hack_alu_pc.sv
// Hack CPU execution slice: combinational 16-bit ALU plus clocked program counter.
// Define HACK_JUMP_EN to add the jmp port and the ALU-flag jump decode into the PC load.
module hack_alu_pc (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] alu_out,
  output logic        zr,
  output logic        ng,
  input  logic [15:0] pc_in,
  input  logic        pc_load,
  input  logic        pc_inc,
`ifdef HACK_JUMP_EN
  input  logic [2:0]  jmp,
`endif
  output logic [15:0] pc_out
);

  logic [15:0] x1_s, x2_s, y1_s, y2_s, r_s;
  logic        load_s;
  logic [15:0] pc_d, pc_q;

  // ALU operand conditioning, function select and output negation
  always_comb begin
    x1_s = zx ? 16'h0000 : x;
    x2_s = nx ? ~x1_s : x1_s;
    y1_s = zy ? 16'h0000 : y;
    y2_s = ny ? ~y1_s : y1_s;
    if (f) begin
      r_s = x2_s + y2_s;
    end else begin
      r_s = x2_s & y2_s;
    end
    alu_out = no ? ~r_s : r_s;
    zr      = (alu_out == 16'h0000);
    ng      = alu_out[15];
  end

`ifdef HACK_JUMP_EN
  logic po_s, take_s;

  // Jump condition from the current ALU flags; gated by pc_inc so A-instructions never jump
  always_comb begin
    po_s   = ~zr & ~ng;
    take_s = (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & po_s);
    load_s = pc_load | (take_s & pc_inc);
  end
`else
  assign load_s = pc_load;
`endif

  // PC next state: load beats increment, increment wraps at 16 bits
  always_comb begin
    if (load_s) begin
      pc_d = pc_in;
    end else if (pc_inc) begin
      pc_d = pc_q + 16'h0001;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register with synchronous reset taking priority over every control
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= 16'h0000;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_out = pc_q;

endmodule

// File: tb/tb_hack_alu_pc.sv
// Scoreboard bench for hack_alu_pc: driver pushes expectations, monitor pops and compares.
module tb_hack_alu_pc;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] x, y, pc_in;
  logic        zx, nx, zy, ny, f, no, pc_load, pc_inc;
  logic [2:0]  jmp_s;
  logic [15:0] alu_out, pc_out;
  logic        zr, ng;

  always #5 clk = ~clk;

  hack_alu_pc dut (
    .clk(clk), .reset(reset), .x(x), .y(y),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .alu_out(alu_out), .zr(zr), .ng(ng),
    .pc_in(pc_in), .pc_load(pc_load), .pc_inc(pc_inc),
`ifdef HACK_JUMP_EN
    .jmp(jmp_s),
`endif
    .pc_out(pc_out)
  );

  typedef struct {
    string       name;
    logic [15:0] alu;
    logic        zr;
    logic        ng;
    logic [15:0] pc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   pc_model = 0;

  // Reference ALU: read straight from the operand rules with integer arithmetic
  function automatic int ref_alu(input logic [5:0] c, input int xv, input int yv);
    int a, b, r;
    a = c[5] ? 0 : xv;
    if (c[4]) a = 65535 - a;
    b = c[3] ? 0 : yv;
    if (c[2]) b = 65535 - b;
    r = c[1] ? (a + b) % 65536 : (a & b);
    if (c[0]) r = 65535 - r;
    return r;
  endfunction

  // One clock of stimulus; expectation describes DUT state just after the next edge
  task automatic step(input string nm, input logic [5:0] c, input logic [15:0] xv,
                      input logic [15:0] yv, input logic rst, input logic ld,
                      input logic inc, input logic [15:0] pin, input logic [2:0] j);
    exp_t e;
    int   a;
    bit   take;
    @(negedge clk);
    {zx, nx, zy, ny, f, no} = c;
    x = xv; y = yv; reset = rst; pc_load = ld; pc_inc = inc; pc_in = pin; jmp_s = j;
    a = ref_alu(c, int'(xv), int'(yv));
    take = 1'b0;
`ifdef HACK_JUMP_EN
    take = (j[2] && a >= 32768) || (j[1] && a == 0) || (j[0] && a > 0 && a < 32768);
`endif
    if (rst) pc_model = 0;
    else if (ld || (take && inc)) pc_model = int'(pin);
    else if (inc) pc_model = (pc_model + 1) % 65536;
    e.name = nm;
    e.alu  = a[15:0];
    e.zr   = (a == 0);
    e.ng   = (a >= 32768);
    e.pc   = pc_model[15:0];
    q.push_back(e);
  endtask

  // Monitor: every edge the DUT presents a new PC and the held ALU inputs' result
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if (alu_out !== e.alu) begin
        fails++;
        $display("FAIL %s alu_out: got %h expected %h", e.name, alu_out, e.alu);
      end
      tests++;
      if (zr !== e.zr || ng !== e.ng) begin
        fails++;
        $display("FAIL %s flags zr/ng: got %b%b expected %b%b", e.name, zr, ng, e.zr, e.ng);
      end
      tests++;
      if (pc_out !== e.pc) begin
        fails++;
        $display("FAIL %s pc_out: got %h expected %h", e.name, pc_out, e.pc);
      end
    end
  end

  localparam logic [5:0] ENC [13] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100,
                                     6'b110000, 6'b001101, 6'b001111, 6'b011111,
                                     6'b000010, 6'b010011, 6'b000111, 6'b000000,
                                     6'b010101};

  // Named-operation semantics, independent of the operand rules
  function automatic logic [15:0] named_op(input int k, input logic [15:0] a, input logic [15:0] b);
    case (k)
      0:  return 16'h0000;
      1:  return 16'h0001;
      2:  return 16'hFFFF;
      3:  return a;
      4:  return b;
      5:  return ~a;
      6:  return 16'h0000 - a;
      7:  return a + 16'h0001;
      8:  return a + b;
      9:  return a - b;
      10: return b - a;
      11: return a & b;
      default: return a | b;
    endcase
  endfunction

  initial begin
    logic [15:0] xv, yv, ev;
    int          wait_cnt;
    reset = 1'b1; x = 16'h0; y = 16'h0; pc_in = 16'h0; pc_load = 1'b0; pc_inc = 1'b0;
    {zx, nx, zy, ny, f, no} = 6'b000000; jmp_s = 3'b000;

    // Reset then count 1,2,3
    step("reset",      6'b101010, 16'h1234, 16'h5678, 1'b1, 1'b0, 1'b0, 16'h0000, 3'b000);
    step("const1",     6'b111111, 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1, 16'h0000, 3'b000);
    step("constm1",    6'b111010, 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1, 16'h0000, 3'b000);
    step("add53",      6'b000010, 16'h0005, 16'h0003, 1'b0, 1'b0, 1'b1, 16'h0000, 3'b000);
    step("xmy",        6'b010011, 16'h0005, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0000, 3'b000);
    step("ymx",        6'b000111, 16'h0005, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0000, 3'b000);
    step("negx",       6'b001111, 16'h0005, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0000, 3'b000);
    step("xp1",        6'b011111, 16'h0005, 16'h0003, 1'b0, 1'b0, 1'b0, 16'h0000, 3'b000);
    step("and",        6'b000000, 16'h00F0, 16'h0F0F, 1'b0, 1'b0, 1'b0, 16'h0000, 3'b000);
    step("or",         6'b010101, 16'h00F0, 16'h0F0F, 1'b0, 1'b0, 1'b0, 16'h0000, 3'b000);
    step("addwrap",    6'b000010, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 3'b000);
    step("rst_vs_ld",  6'b101010, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h00AA, 3'b111);
    step("ld_beats_inc", 6'b111111, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hFFFF, 3'b000);
    step("pc_wrap",    6'b111111, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 3'b000);
    step("pc_hold",    6'b111111, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h1111, 3'b000);
    step("pc_set10",   6'b111111, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0010, 3'b000);
    step("jeq_zero",   6'b101010, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0040, 3'b010);
    step("pc_set10b",  6'b111111, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0010, 3'b000);
    step("jne_zero",   6'b101010, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0040, 3'b101);
    step("pc_set10c",  6'b111111, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0010, 3'b000);
    step("jlt_neg",    6'b111010, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0040, 3'b100);
    step("jmp_no_inc", 6'b111010, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0080, 3'b111);

    // Named-operation table on random operands, checked directly at mid-cycle
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 13; k++) begin
        @(negedge clk);
        xv = 16'($urandom); yv = 16'($urandom);
        {zx, nx, zy, ny, f, no} = ENC[k];
        x = xv; y = yv;
        #1;
        ev = named_op(k, xv, yv);
        tests++;
        if (alu_out !== ev) begin
          fails++;
          $display("FAIL named_op%0d x=%h y=%h: got %h expected %h", k, xv, yv, alu_out, ev);
        end
      end
    end

    // Randomized mix of ALU codes and PC controls
    for (int i = 0; i < 300; i++) begin
      step("random", 6'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom),
           16'($urandom), 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 4) == 0),
           1'($urandom), 16'($urandom), 3'($urandom));
    end

    wait_cnt = 0;
    while (q.size() > 0 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
